vec_wb_arbiter: RTL

//  Receiving end of the execution-unit result stream. Merges NUM_SRC vector-result streams
//  (tensor exe, SFU, ...; each a data/mask/wvd/reg_idxw/warp_id beat with valid/ready) into one

---
 rtl/vec_wb_arbiter_pkg.sv | 18 +
 rtl/vec_wb_arbiter_rr.sv | 51 +++++
 rtl/vec_wb_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vec_wb_arbiter_pkg.sv
// Shared definitions for the vector writeback arbiter.
// The DEF_* values mirror define.v (`NUM_THREAD, `XLEN, `REGIDX_WIDTH,
// `REGEXT_WIDTH, `DEPTH_WARP) and are only the defaults of the top-level
// parameters. The arbiter itself adds no shared constants.
package vec_wb_arbiter_pkg;

  localparam int unsigned DEF_NUM_THREAD   = 4;
  localparam int unsigned DEF_XLEN         = 32;
  localparam int unsigned DEF_REGIDX_WIDTH = 5;
  localparam int unsigned DEF_REGEXT_WIDTH = 3;
  localparam int unsigned DEF_DEPTH_WARP   = 3;

  // Width of a pointer that selects one of n sources. A single source still gets one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_wb_arbiter_rr.sv
// Round-robin grant logic. This block is purely combinational; the pointer register
// is kept in the parent module.
// Ports:
//   req        in   N   request vector
//   ptr        in   PW  highest-priority source
//   en         in   1   gate that allows a grant
//   grant_c    out  N   one-hot grant, or zero
//   next_ptr_c out  PW  the source after the winner, wrapping to 0
module rr_arbiter
  import vec_wb_arbiter_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant_c,
  output logic [PW-1:0] next_ptr_c
);

  int   w_dist;
  int   w_best;
  int   w_win;
  logic w_hit;

  // Winner = the requester at the smallest wrapped distance from ptr.
  always_comb begin
    grant_c    = '0;
    next_ptr_c = ptr;
    w_dist     = 0;
    w_best     = int'(N);
    w_win      = 0;
    w_hit      = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + int'(N) - int'(ptr));
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = i;
        w_hit  = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      grant_c[i] = en && w_hit && (w_win == i);
    end
    if (w_hit) begin
      next_ptr_c = (w_win == int'(N) - 1) ? '0 : PW'(w_win + 1);
    end
  end

endmodule

// File: rtl/vec_wb_arbiter.sv
// Merges NUM_SRC vector-result streams into one vector-register-file write port.
// Sources are served round-robin, and the write port is a one-entry registered slot.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   in_valid_i      per-source beat valid
//   in_ready_o      per-source ready (one-hot or zero). Combinational from valid and out_ready.
//   in_wvd_rd_i     per-source lane data, source s at [s*VL*XLEN +: VL*XLEN]
//   in_wvd_mask_i   per-source lane mask
//   in_wvd_i        per-source "writes vector reg". A zero means the beat is consumed and dropped.
//   in_reg_idxw_i   per-source destination register
//   in_warp_id_i    per-source warp id
//   out_valid_o     write beat valid
//   out_ready_i     writeback accepts the beat
//   out_wvd_rd_o, out_wvd_mask_o, out_reg_idxw_o, out_warp_id_o   payload of the beat
//   out_src_o       one-hot source of the current beat
module vec_wb_arbiter
  import vec_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned VL      = DEF_NUM_THREAD,
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned REGW    = DEF_REGIDX_WIDTH + DEF_REGEXT_WIDTH,
  parameter int unsigned WARPW   = DEF_DEPTH_WARP
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        in_valid_i,
  output logic [NUM_SRC-1:0]        in_ready_o,
  input  logic [NUM_SRC*VL*XLEN-1:0] in_wvd_rd_i,
  input  logic [NUM_SRC*VL-1:0]     in_wvd_mask_i,
  input  logic [NUM_SRC-1:0]        in_wvd_i,
  input  logic [NUM_SRC*REGW-1:0]   in_reg_idxw_i,
  input  logic [NUM_SRC*WARPW-1:0]  in_warp_id_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [VL*XLEN-1:0]        out_wvd_rd_o,
  output logic [VL-1:0]             out_wvd_mask_o,
  output logic [REGW-1:0]           out_reg_idxw_o,
  output logic [WARPW-1:0]          out_warp_id_o,
  output logic [NUM_SRC-1:0]        out_src_o
);

  localparam int unsigned PW = ptr_width(NUM_SRC);
  localparam int unsigned DW = VL * XLEN;

  logic [PW-1:0]      r_ptr;
  logic               r_valid;
  logic [DW-1:0]      r_rd;
  logic [VL-1:0]      r_mask;
  logic [REGW-1:0]    r_idx;
  logic [WARPW-1:0]   r_warp;
  logic [NUM_SRC-1:0] r_src;

  logic               w_can_take;
  logic [NUM_SRC-1:0] w_grant;
  logic [PW-1:0]      w_next_ptr;
  logic               w_accept;
  logic               w_load;
  logic [DW-1:0]      w_rd;
  logic [VL-1:0]      w_mask;
  logic [REGW-1:0]    w_idx;
  logic [WARPW-1:0]   w_warp;

  // The slot can take a beat when it is empty or is being drained this cycle.
  assign w_can_take = !r_valid || out_ready_i;

  rr_arbiter #(.N(NUM_SRC), .PW(PW)) u_rr (
    .req        (in_valid_i),
    .ptr        (r_ptr),
    .en         (w_can_take),
    .grant_c    (w_grant),
    .next_ptr_c (w_next_ptr)
  );

  assign in_ready_o = w_grant;
  assign w_accept   = |w_grant;
  assign w_load     = |(w_grant & in_wvd_i);

  // Payload mux, selected by the one-hot grant.
  always_comb begin
    w_rd   = '0;
    w_mask = '0;
    w_idx  = '0;
    w_warp = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (w_grant[s]) begin
        w_rd   = in_wvd_rd_i[s*DW +: DW];
        w_mask = in_wvd_mask_i[s*VL +: VL];
        w_idx  = in_reg_idxw_i[s*REGW +: REGW];
        w_warp = in_warp_id_i[s*WARPW +: WARPW];
      end
    end
  end

  // Pointer and output slot. On a drain with no load, the payload holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_mask  <= '0;
      r_idx   <= '0;
      r_warp  <= '0;
      r_src   <= '0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_next_ptr;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_rd    <= w_rd;
        r_mask  <= w_mask;
        r_idx   <= w_idx;
        r_warp  <= w_warp;
        r_src   <= w_grant;
      end else if (out_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o    = r_valid;
  assign out_wvd_rd_o   = r_rd;
  assign out_wvd_mask_o = r_mask;
  assign out_reg_idxw_o = r_idx;
  assign out_warp_id_o  = r_warp;
  assign out_src_o      = r_src;

endmodule
